// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the sequential ALU.
// Op encodings, FSM states and the op-field width.
package alu_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_AND = 3'b000,
        ALU_ADD = 3'b001,
        ALU_XOR = 3'b010,
        ALU_SLT = 3'b011,
        ALU_SLL = 3'b100,
        ALU_SRL = 3'b101,
        ALU_SNE = 3'b110,
        ALU_MUL = 3'b111
    } alu_op_e;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier, one bit per cycle.
// done is high in the cycle whose edge completes the last iteration.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] addend;

    // partial sum including this cycle's step, so the last
    // iteration's value is visible while done is high
    assign addend  = mplier[0] ? mcand : '0;
    assign product = acc + addend;
    assign done    = (cnt == CNT_W'(1));

    // load on start, then one shift-add step per cycle until the counter empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            cnt    <= CNT_W'(WIDTH);
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
        end else if (cnt != '0) begin
            cnt    <= cnt - CNT_W'(1);
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on both sides.
// Define ALU_MUL_EN to make op 111 an iterative multiply; otherwise it is a NOP.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [ALU_OP_W-1:0] alu_op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic                zero,
    output logic                carry
);

    logic             accept;
    logic             load;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] dp_res;
    logic             dp_carry;
    logic [WIDTH-1:0] nxt_res;
    logic             nxt_carry;

    assign accept = in_valid && in_ready;
    assign sum    = {1'b0, a} + {1'b0, b};

    // single-cycle datapath; shifts by >= WIDTH naturally give zero
    always_comb begin
        dp_res   = '0;
        dp_carry = 1'b0;
        unique case (alu_op_e'(alu_op))
            ALU_AND: dp_res = a & b;
            ALU_ADD: begin
                dp_res   = sum[WIDTH-1:0];
                dp_carry = sum[WIDTH];
            end
            ALU_XOR: dp_res = a ^ b;
            ALU_SLT: dp_res = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_SLL: dp_res = a << b;
            ALU_SRL: dp_res = a >> b;
            ALU_SNE: dp_res = {{(WIDTH-1){1'b0}}, (a != b)};
            ALU_MUL: dp_res = '0;
            default: dp_res = '0;
        endcase
    end

`ifdef ALU_MUL_EN

    alu_state_e         state_q;
    alu_state_e         state_d;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    assign in_ready = (state_q == IDLE) && (!out_valid || out_ready);

    alu_mul_seq #(
        .WIDTH   (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_prod)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next state, multiplier start and output-register load selection
    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        load      = 1'b0;
        nxt_res   = dp_res;
        nxt_carry = dp_carry;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (alu_op_e'(alu_op) == ALU_MUL) begin
                        mul_start = 1'b1;
                        state_d   = MUL_BUSY;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            MUL_BUSY: begin
                if (mul_done) begin
                    load      = 1'b1;
                    nxt_res   = mul_prod[WIDTH-1:0];
                    nxt_carry = |mul_prod[2*WIDTH-1:WIDTH];
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`else

    assign in_ready  = !out_valid || out_ready;
    assign load      = accept;
    assign nxt_res   = dp_res;
    assign nxt_carry = dp_carry;

`endif

    // output register: a new load wins over a drain at the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            result    <= nxt_res;
            zero      <= (nxt_res == '0);
            carry     <= nxt_carry;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq at WIDTH=8.
// Expected values come from an arithmetic model of the op table.
module tb_alu_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   alu_op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;

    int n_checks = 0;
    int n_fails  = 0;

    alu_seq #(
        .WIDTH     (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     tag, got, got, exp, exp);
        end
    endtask

    // reference op table written as plain integer arithmetic
    function automatic void model(input int op, input int x, input int y,
                                  output int res, output int cy);
        int p;
        res = 0;
        cy  = 0;
        case (op)
            0: res = x & y;
            1: begin
                p   = x + y;
                res = p % 256;
                cy  = (p >= 256) ? 1 : 0;
            end
            2: res = x ^ y;
            3: res = (x < y) ? 1 : 0;
            4: res = (y >= W) ? 0 : ((x * (1 << y)) % 256);
            5: res = (y >= W) ? 0 : (x / (1 << y));
            6: res = (x != y) ? 1 : 0;
            default: begin
`ifdef ALU_MUL_EN
                p   = x * y;
                res = p % 256;
                cy  = (p >= 256) ? 1 : 0;
`else
                res = 0;
`endif
            end
        endcase
    endfunction

    function automatic bit is_mul(input int op);
`ifdef ALU_MUL_EN
        return op == 7;
`else
        return 1'b0;
`endif
    endfunction

    // present one op, wait for acceptance, then check latency and outputs
    task automatic issue(input string tag, input int op, input int x, input int y);
        int er;
        int ec;
        int k;
        model(op, x, y, er, ec);
        alu_op   = 3'(op);
        a        = 8'(x);
        b        = 8'(y);
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !in_ready; i++) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_rdy"}, 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (is_mul(op)) begin
            k = 0;
            check({tag, "_busy_vld"}, 32'(out_valid), 0);
            check({tag, "_busy_rdy"}, 32'(in_ready), 0);
            while (k < 20) begin
                @(posedge clk);
                #1;
                k++;
                if (out_valid) break;
                check({tag, "_busy_rdy"}, 32'(in_ready), 0);
            end
            check({tag, "_lat"}, k, W);
        end
        check({tag, "_vld"}, 32'(out_valid), 1);
        check({tag, "_res"}, 32'(result), er);
        check({tag, "_zero"}, 32'(zero), (er == 0) ? 1 : 0);
        check({tag, "_carry"}, 32'(carry), ec);
    endtask

    initial begin
        int r_op;
        int r_a;
        int r_b;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        alu_op    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", 32'(out_valid), 0);
        check("rst_res", 32'(result), 0);
        check("rst_zero", 32'(zero), 0);
        check("rst_carry", 32'(carry), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rdy_after_rst", 32'(in_ready), 1);

        issue("add", 1, 200, 100);
        issue("xor", 2, 8'h5A, 8'h5A);
        issue("sll1", 4, 8'h81, 1);
        issue("sll8", 4, 8'h81, 8);
        issue("srl7", 5, 8'h80, 7);
        issue("op7a", 7, 13, 11);
        issue("op7b", 7, 16, 16);
        issue("op7c", 7, 5, 5);

        // backpressure: hold the ADD result, then drain and accept at one edge
        issue("bp_add", 1, 250, 9);
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("bp_hold_vld", 32'(out_valid), 1);
            check("bp_hold_res", 32'(result), 3);
            check("bp_hold_carry", 32'(carry), 1);
            check("bp_rdy", 32'(in_ready), 0);
        end
        alu_op    = 3'd3;
        a         = 8'd3;
        b         = 8'd5;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("bp_same_edge_rdy", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_slt_vld", 32'(out_valid), 1);
        check("bp_slt_res", 32'(result), 1);
        check("bp_slt_carry", 32'(carry), 0);
        @(posedge clk);
        #1;
        check("drain_vld", 32'(out_valid), 0);

        // asynchronous reset in the middle of outstanding work
`ifdef ALU_MUL_EN
        alu_op   = 3'd7;
        a        = 8'd13;
        b        = 8'd11;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
`else
        out_ready = 1'b0;
        alu_op    = 3'd1;
        a         = 8'd9;
        b         = 8'd9;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
`endif
        rst_n = 1'b0;
        #1;
        check("arst_vld", 32'(out_valid), 0);
        check("arst_res", 32'(result), 0);
        check("arst_zero", 32'(zero), 0);
        check("arst_carry", 32'(carry), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
`ifdef ALU_MUL_EN
        repeat (10) begin
            @(posedge clk);
            #1;
            check("arst_no_late_mul", 32'(out_valid), 0);
        end
`endif
        issue("and_after_rst", 0, 8'hF0, 8'h3C);

        // random back-to-back stream
        for (int i = 0; i < 40; i++) begin
            r_op = int'($urandom_range(0, 7));
            r_a  = int'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) r_b = int'($urandom_range(0, 255));
            else                           r_b = int'($urandom_range(0, 11));
            issue($sformatf("rnd%0d_op%0d", i, r_op), r_op, r_a, r_b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
